dtw_axis_sample_fifo: RTL and testbench

Parametrised successor to the DTW accelerator's AXI4-Stream sink. It accepts TDATA words of any width, buffers them in a power-of-two word FIFO, and unpacks each word into SAMPLE_WIDTH-bit samples. Samples are presented show-ahead to the DTW core one per read, skipping lanes removed by TSTRB and marking packet ends with a last flag. It sits between the DMA stream and the DTW core and replaces the fixed 8-bit, 8-entry sink.

---
 rtl/dtw_axis_pkg.sv | 30 +++
 rtl/dtw_word_fifo.sv | 50 +++++
 rtl/dtw_axis_sample_fifo.sv | 122 ++++++++++++
 tb/tb_dtw_axis_sample_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_axis_pkg.sv
// Shared definitions for the DTW AXI4-Stream sample sink: sizing helpers,
// lane priority search and dtw_err bit positions.
package dtw_axis_pkg;

   localparam int MAX_LANES     = 64;
   localparam int ERR_PARTIAL   = 0;
   localparam int ERR_LOST_LAST = 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int lanes(input int tdata_width, input int sample_width);
      return tdata_width / sample_width;
   endfunction

   // Lowest set lane strictly above 'from' (from = -1 gives the lowest lane), -1 if none.
   function automatic int lowest_above(input logic [MAX_LANES-1:0] m, input int from);
      int r;
      r = -1;
      for (int i = MAX_LANES - 1; i >= 0; i--) begin
         if (m[i] && (i > from)) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/dtw_word_fifo.sv
// Power-of-two word FIFO with show-ahead head output; storage is not reset.
module dtw_word_fifo
   import dtw_axis_pkg::*;
#(
   parameter  int WIDTH = 41,
   parameter  int DEPTH = 8,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dtw_axis_sample_fifo.sv
// AXI4-Stream sink for the DTW core: buffers TDATA words and unpacks them into
// show-ahead samples, skipping strobed-out lanes and flagging packet ends.
module dtw_axis_sample_fifo
   import dtw_axis_pkg::*;
#(
   parameter  int C_S_AXIS_TDATA_WIDTH = 32,
   parameter  int SAMPLE_WIDTH         = 8,
   parameter  int FIFO_DEPTH           = 8,
   localparam int AW                   = clog2(FIFO_DEPTH)
) (
   input  logic                              S_AXIS_ACLK,
   input  logic                              S_AXIS_ARESET,
   input  logic                              S_AXIS_TVALID,
   output logic                              S_AXIS_TREADY,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
   input  logic                              S_AXIS_TLAST,
   input  logic                              dtw_fifo_flush,
   input  logic                              dtw_fifo_rden,
   output logic [SAMPLE_WIDTH-1:0]           dtw_fifo_dout,
   output logic                              dtw_fifo_empty,
   output logic                              dtw_fifo_last,
   output logic [AW:0]                       dtw_fifo_level,
   output logic [1:0]                        dtw_err
);

   localparam int LANES = lanes(C_S_AXIS_TDATA_WIDTH, SAMPLE_WIDTH);
   localparam int BPL   = SAMPLE_WIDTH / 8;
   localparam int WW    = C_S_AXIS_TDATA_WIDTH + LANES + 1;
   localparam int CW    = (LANES > 1) ? clog2(LANES) : 1;

   logic                            ready_en;
   logic                            hs;
   logic                            push;
   logic                            pop;
   logic                            rd_take;
   logic [LANES-1:0]                lane_mask;
   logic [LANES-1:0]                lane_part;
   logic [WW-1:0]                   fifo_head;
   logic                            head_last;
   logic [LANES-1:0]                head_mask;
   logic [C_S_AXIS_TDATA_WIDTH-1:0] head_data;
   logic [LANES-1:0]                done;
   logic [LANES-1:0]                rem;
   logic [MAX_LANES-1:0]            rem_ext;
   logic [LANES-1:0]                cursor_1h;
   logic [CW-1:0]                   cursor;
   logic                            at_end;
   int                              cur_i;

   // Handshake: a word transfers on a rising edge where TVALID && TREADY.
   // TREADY never looks at same-cycle rden and is forced low while flushing.
   assign S_AXIS_TREADY = ready_en && (dtw_fifo_level < (AW+1)'(FIFO_DEPTH)) && !dtw_fifo_flush;
   assign hs            = S_AXIS_TVALID && S_AXIS_TREADY;

   always_comb begin
      lane_mask = '0;
      lane_part = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_mask[i] = &S_AXIS_TSTRB[i*BPL +: BPL];
         lane_part[i] = (|S_AXIS_TSTRB[i*BPL +: BPL]) && !lane_mask[i];
      end
   end

   assign push = hs && (|lane_mask);

   dtw_word_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_word_fifo (
      .clk   (S_AXIS_ACLK),
      .rst   (S_AXIS_ARESET),
      .flush (dtw_fifo_flush),
      .push  (push),
      .pop   (pop),
      .din   ({S_AXIS_TLAST, lane_mask, S_AXIS_TDATA}),
      .head  (fifo_head),
      .level (dtw_fifo_level)
   );

   assign {head_last, head_mask, head_data} = fifo_head;
   assign dtw_fifo_empty = (dtw_fifo_level == '0);

   // The cursor is the lowest valid lane of the head word not yet consumed.
   always_comb begin
      rem                = head_mask & ~done;
      rem_ext            = '0;
      rem_ext[LANES-1:0] = rem;
      cur_i              = lowest_above(rem_ext, -1);
      at_end             = (lowest_above(rem_ext, cur_i) < 0);
      cursor             = CW'(cur_i);
      cursor_1h          = LANES'(1) << cursor;
   end

   assign rd_take = dtw_fifo_rden && !dtw_fifo_empty && !dtw_fifo_flush;
   assign pop     = rd_take && at_end;

   assign dtw_fifo_dout = dtw_fifo_empty ? '0 : head_data[cursor*SAMPLE_WIDTH +: SAMPLE_WIDTH];
   assign dtw_fifo_last = !dtw_fifo_empty && head_last && at_end;

   always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
      if (S_AXIS_ARESET) begin
         ready_en <= 1'b0;
         done     <= '0;
         dtw_err  <= '0;
      end else begin
         ready_en <= 1'b1;
         if (dtw_fifo_flush) begin
            done    <= '0;
            dtw_err <= '0;
         end else begin
            if (pop)          done <= '0;
            else if (rd_take) done <= done | cursor_1h;
            if (hs && (|lane_part))
               dtw_err[ERR_PARTIAL] <= 1'b1;
            if (hs && (lane_mask == '0) && S_AXIS_TLAST)
               dtw_err[ERR_LOST_LAST] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dtw_axis_sample_fifo.sv
// Directed bench for dtw_axis_sample_fifo: expected samples are queued as words
// are sent, and monitors compare them as the DTW side consumes samples.
module tb_dtw_axis_sample_fifo;

   logic        clk;
   logic        rst;
   logic        tvalid, tready, tlast;
   logic [31:0] tdata;
   logic [3:0]  tstrb;
   logic        flush, rden;
   logic [7:0]  dout;
   logic        empty, last;
   logic [3:0]  level;
   logic [1:0]  err;

   logic        tvalid16, tready16, tlast16;
   logic [31:0] tdata16;
   logic [3:0]  tstrb16;
   logic        flush16, rden16;
   logic [15:0] dout16;
   logic        empty16, last16;
   logic [3:0]  level16;
   logic [1:0]  err16;

   int checks = 0;
   int errors = 0;

   logic [8:0]  exp_q[$];
   logic [16:0] exp16_q[$];
   logic [8:0]  mon_e;
   logic [16:0] mon_e16;

   dtw_axis_sample_fifo #(.C_S_AXIS_TDATA_WIDTH(32), .SAMPLE_WIDTH(8), .FIFO_DEPTH(8)) dut (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
      .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast),
      .dtw_fifo_flush(flush), .dtw_fifo_rden(rden), .dtw_fifo_dout(dout),
      .dtw_fifo_empty(empty), .dtw_fifo_last(last), .dtw_fifo_level(level), .dtw_err(err)
   );

   dtw_axis_sample_fifo #(.C_S_AXIS_TDATA_WIDTH(32), .SAMPLE_WIDTH(16), .FIFO_DEPTH(8)) dut16 (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TVALID(tvalid16), .S_AXIS_TREADY(tready16),
      .S_AXIS_TDATA(tdata16), .S_AXIS_TSTRB(tstrb16), .S_AXIS_TLAST(tlast16),
      .dtw_fifo_flush(flush16), .dtw_fifo_rden(rden16), .dtw_fifo_dout(dout16),
      .dtw_fifo_empty(empty16), .dtw_fifo_last(last16), .dtw_fifo_level(level16), .dtw_err(err16)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // scoreboard monitors: compare {last, dout} whenever a sample is consumed
   always @(negedge clk) begin
      if (!rst && rden && !empty) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sample8 actual=%h/%0d required=none", dout, last);
         end else begin
            mon_e = exp_q.pop_front();
            if ({last, dout} !== mon_e) begin
               errors++;
               $display("FAIL sample8 actual=%h/%0d required=%h/%0d", dout, last, mon_e[7:0], mon_e[8]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && rden16 && !empty16) begin
         checks++;
         if (exp16_q.size() == 0) begin
            errors++;
            $display("FAIL sample16 actual=%h/%0d required=none", dout16, last16);
         end else begin
            mon_e16 = exp16_q.pop_front();
            if ({last16, dout16} !== mon_e16) begin
               errors++;
               $display("FAIL sample16 actual=%h/%0d required=%h/%0d", dout16, last16, mon_e16[15:0], mon_e16[16]);
            end
         end
      end
   end

   // driver tasks (called at posedge+1, return at posedge+1 after the handshake)
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n;
      tvalid = 1'b1; tdata = d; tstrb = s; tlast = l;
      n = 0;
      @(negedge clk);
      while (!tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!tready) chk("send_tready_timeout", 32'(tready), 32'd1);
      @(posedge clk);
      #1 tvalid = 1'b0;
   endtask

   task automatic send16(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n;
      tvalid16 = 1'b1; tdata16 = d; tstrb16 = s; tlast16 = l;
      n = 0;
      @(negedge clk);
      while (!tready16 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!tready16) chk("send16_tready_timeout", 32'(tready16), 32'd1);
      @(posedge clk);
      #1 tvalid16 = 1'b0;
   endtask

   // Dense word k carries bytes k*4+0..k*4+3; every fifth word ends a packet.
   task automatic push_word(input int k);
      logic l;
      l = ((k % 5) == 4);
      for (int j = 0; j < 4; j++) exp_q.push_back({(l && j == 3), 8'(k*4 + j)});
      send({8'(k*4+3), 8'(k*4+2), 8'(k*4+1), 8'(k*4)}, 4'hF, l);
   endtask

   task automatic read_n(input int n);
      rden = 1'b1;
      repeat (n) @(posedge clk);
      #1 rden = 1'b0;
   endtask

   task automatic flush_pulse();
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      tvalid = 0; tdata = 0; tstrb = 0; tlast = 0; flush = 0; rden = 0;
      tvalid16 = 0; tdata16 = 0; tstrb16 = 0; tlast16 = 0; flush16 = 0; rden16 = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("tready_before_first_edge", 32'(tready), 32'd0);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_level", 32'(level), 32'd0);
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_last", 32'(last), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      @(posedge clk);
      #1 chk("tready_after_release", 32'(tready), 32'd1);

      // dense word, read back at one sample per cycle
      exp_q.push_back({1'b0, 8'h11});
      exp_q.push_back({1'b0, 8'h22});
      exp_q.push_back({1'b0, 8'h33});
      exp_q.push_back({1'b1, 8'h44});
      send(32'h44332211, 4'hF, 1'b1);
      chk("dense_level", 32'(level), 32'd1);
      chk("dense_first_dout", 32'(dout), 32'h11);
      read_n(4);
      chk("dense_empty_after", 32'(empty), 32'd1);

      // sparse and null words
      exp_q.push_back({1'b0, 8'hBB});
      exp_q.push_back({1'b0, 8'hDD});
      send(32'hDDCCBBAA, 4'b1010, 1'b0);
      send(32'h12345678, 4'b0000, 1'b0);
      chk("null_word_level", 32'(level), 32'd1);
      chk("null_word_err", 32'(err), 32'd0);
      send(32'h12345678, 4'b0000, 1'b1);
      chk("null_last_err", 32'(err), 32'd2);
      read_n(2);
      chk("sparse_empty_after", 32'(empty), 32'd1);
      flush_pulse();
      chk("flush_clears_err", 32'(err), 32'd0);

      // full, pop-to-not-full, push during final-lane pop, then streaming wrap
      for (int k = 0; k < 8; k++) push_word(k);
      chk("full_level", 32'(level), 32'd8);
      chk("full_tready", 32'(tready), 32'd0);
      rden = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("pop_one_level", 32'(level), 32'd7);
      chk("pop_one_tready", 32'(tready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      push_word(8);
      rden = 1'b0;
      chk("push_pop_level", 32'(level), 32'd7);
      push_word(9);
      chk("refill_level", 32'(level), 32'd8);
      chk("refill_tready", 32'(tready), 32'd0);
      rden = 1'b1;
      for (int k = 10; k < 30; k++) push_word(k);
      n = 0;
      @(negedge clk);
      while (!empty && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("stream_drained", 32'(empty), 32'd1);
      @(posedge clk);
      #1 rden = 1'b0;
      chk("stream_level", 32'(level), 32'd0);

      // flush mid-packet with a concurrent word
      send(32'h0, 4'h0, 1'b1);
      for (int k = 0; k < 3; k++) send(32'hA5A5A5A5, 4'hF, 1'b0);
      chk("preflush_level", 32'(level), 32'd3);
      chk("preflush_err", 32'(err), 32'd2);
      flush = 1'b1; tvalid = 1'b1; tdata = 32'h99999999; tstrb = 4'hF; tlast = 1'b0;
      @(negedge clk);
      chk("flush_tready", 32'(tready), 32'd0);
      @(posedge clk);
      #1 flush = 1'b0; tvalid = 1'b0;
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_err", 32'(err), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b1, 8'h0D});
      send(32'h0D0C0B0A, 4'b1100, 1'b1);
      read_n(2);
      chk("postflush_empty", 32'(empty), 32'd1);

      // 16-bit samples with a partially strobed lane
      exp16_q.push_back({1'b1, 16'hBBBB});
      send16(32'hAAAABBBB, 4'b0111, 1'b1);
      chk("w16_level", 32'(level16), 32'd1);
      chk("w16_last", 32'(last16), 32'd1);
      chk("w16_err", 32'(err16), 32'd1);
      rden16 = 1'b1;
      @(posedge clk);
      #1 rden16 = 1'b0;
      chk("w16_empty", 32'(empty16), 32'd1);

      // asynchronous reset in the middle of a burst
      send(32'h0, 4'h0, 1'b1);
      send(32'h11223344, 4'hF, 1'b0);
      tvalid = 1'b1; tdata = 32'h55667788; tstrb = 4'hF; tlast = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst_tready", 32'(tready), 32'd0);
      chk("midrst_empty", 32'(empty), 32'd1);
      chk("midrst_level", 32'(level), 32'd0);
      chk("midrst_dout", 32'(dout), 32'd0);
      chk("midrst_last", 32'(last), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("midrst_err16", 32'(err16), 32'd0);
      tvalid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_tready_release", 32'(tready), 32'd0);
      @(posedge clk);
      #1 chk("midrst_tready_edge", 32'(tready), 32'd1);

      chk("exp_q_leftover", 32'(exp_q.size()), 32'd0);
      chk("exp16_q_leftover", 32'(exp16_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
